// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the two-requester shared-ALU arbiter.
package alu_ctrl_pkg;

    localparam int OPCODE_W  = 4;
    localparam int WIDTH_DEF = 16;
    localparam int NUM_REQ   = 2;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer breaks ties and flips to the loser on every grant.
module rr_arb2
    import alu_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic               win_id
);

    logic ptr;

    always_comb begin
        win_id = 1'b0;
        case (req)
            2'b01:   win_id = 1'b0;
            2'b10:   win_id = 1'b1;
            2'b11:   win_id = ptr;
            default: win_id = 1'b0;
        endcase
        grant = (en && |req) ? onehot2(win_id) : '0;
    end

    // A grant is only issued together with a valid request, so it marks the accept.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (|grant)
            ptr <= ~win_id;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU, one operation in flight,
// with a fixed-latency wait and a held response until the owner consumes it.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ALU_LAT = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]    req_A,
    input  logic [NUM_REQ*WIDTH-1:0]    req_B,
    input  logic [NUM_REQ*OPCODE_W-1:0] req_opcode,
    input  logic [NUM_REQ-1:0]          req_Cin,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [WIDTH-1:0]            rsp_Y,
    output logic                        rsp_Cout,
    output logic [WIDTH-1:0]            alu_A,
    output logic [WIDTH-1:0]            alu_B,
    output logic [OPCODE_W-1:0]         alu_opcode,
    output logic                        alu_Cin,
    input  logic [WIDTH-1:0]            alu_Y,
    input  logic                        alu_Cout,
    output logic                        busy,
    output logic                        grant_id
);

    state_t                            state;
    logic [CNT_W-1:0]                  cnt;
    logic [NUM_REQ-1:0]                grant;
    logic                              win_id;
    logic                              accept;
    logic [NUM_REQ-1:0][WIDTH-1:0]     a_v;
    logic [NUM_REQ-1:0][WIDTH-1:0]     b_v;
    logic [NUM_REQ-1:0][OPCODE_W-1:0]  op_v;

    for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
        assign a_v[n]  = req_A[n*WIDTH +: WIDTH];
        assign b_v[n]  = req_B[n*WIDTH +: WIDTH];
        assign op_v[n] = req_opcode[n*OPCODE_W +: OPCODE_W];
    end

    rr_arb2 u_arb (
        .clk    (CLK),
        .rst    (RST),
        .req    (req_valid),
        .en     (state == IDLE && !RST),
        .grant  (grant),
        .win_id (win_id)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            grant_id   <= 1'b0;
            rsp_valid  <= '0;
            rsp_Y      <= '0;
            rsp_Cout   <= 1'b0;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_opcode <= '0;
            alu_Cin    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_A      <= a_v[win_id];
                        alu_B      <= b_v[win_id];
                        alu_opcode <= op_v[win_id];
                        alu_Cin    <= req_Cin[win_id];
                        grant_id   <= win_id;
                        cnt        <= CNT_W'(ALU_LAT);
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rsp_Y     <= alu_Y;
                        rsp_Cout  <= alu_Cout;
                        rsp_valid <= onehot2(grant_id);
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // Only the owner's ready completes the handshake.
                    if (rsp_ready[grant_id]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle, plus directed literal checks.
module tb_alu_arbiter;

    localparam int W   = 16;
    localparam int LAT = 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [1:0]     req_valid, req_ready, req_Cin, rsp_valid, rsp_ready;
    logic [2*W-1:0] req_A, req_B;
    logic [7:0]     req_opcode;
    logic [W-1:0]   rsp_Y, alu_A, alu_B, alu_Y;
    logic           rsp_Cout, alu_Cin, alu_Cout, busy, grant_id;
    logic [3:0]     alu_opcode;

    logic [1:0]     z_req_valid, z_req_ready, z_req_Cin, z_rsp_valid, z_rsp_ready;
    logic [2*W-1:0] z_req_A, z_req_B;
    logic [7:0]     z_req_opcode;
    logic [W-1:0]   z_rsp_Y, z_alu_A, z_alu_B, z_alu_Y;
    logic           z_rsp_Cout, z_alu_Cin, z_alu_Cout, z_busy, z_grant_id;
    logic [3:0]     z_alu_opcode;

    alu_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_A(req_A), .req_B(req_B),
        .req_opcode(req_opcode), .req_Cin(req_Cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_Y(rsp_Y), .rsp_Cout(rsp_Cout),
        .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode), .alu_Cin(alu_Cin),
        .alu_Y(alu_Y), .alu_Cout(alu_Cout), .busy(busy), .grant_id(grant_id)
    );

    alu_arbiter #(.WIDTH(W), .ALU_LAT(0)) dut0 (
        .CLK(CLK), .RST(RST),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_A(z_req_A), .req_B(z_req_B),
        .req_opcode(z_req_opcode), .req_Cin(z_req_Cin),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_Y(z_rsp_Y), .rsp_Cout(z_rsp_Cout),
        .alu_A(z_alu_A), .alu_B(z_alu_B), .alu_opcode(z_alu_opcode), .alu_Cin(z_alu_Cin),
        .alu_Y(z_alu_Y), .alu_Cout(z_alu_Cout), .busy(z_busy), .grant_id(z_grant_id)
    );

    // Bench ALU: opcode 0 adds with carry, anything else is XOR with no carry.
    function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] op, input logic cin);
        if (op == 4'd0) return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        return {1'b0, a ^ b};
    endfunction

    always @(posedge CLK) {alu_Cout, alu_Y} <= alu_f(alu_A, alu_B, alu_opcode, alu_Cin);
    assign {z_alu_Cout, z_alu_Y} = alu_f(z_alu_A, z_alu_B, z_alu_opcode, z_alu_Cin);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: 0 free, 1 waiting m_left edges for result, 2 result held.
    int         m_phase = 0;
    int         m_left  = 0;
    logic       m_ptr   = 1'b0;
    logic       m_gid   = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [3:0] m_op  = '0;
    logic       m_cin = 1'b0;
    logic [W:0] m_res = '0;
    bit         armed = 1'b0;

    function automatic logic win_of(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p;
        return v[1];
    endfunction

    task model_step();
        logic w;
        if (RST) begin
            m_phase = 0; m_ptr = 1'b0; m_gid = 1'b0;
            m_a = '0; m_b = '0; m_op = '0; m_cin = 1'b0;
            armed = 1'b1;
        end else if (m_phase == 0) begin
            if (req_valid != 2'b00) begin
                w      = win_of(req_valid, m_ptr);
                m_gid  = w;
                m_ptr  = ~w;
                m_a    = req_A[w*W +: W];
                m_b    = req_B[w*W +: W];
                m_op   = req_opcode[w*4 +: 4];
                m_cin  = req_Cin[w];
                m_res  = alu_f(m_a, m_b, m_op, m_cin);
                m_left = LAT + 1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) m_phase = 2;
        end else if (rsp_ready[m_gid]) begin
            m_phase = 0;
        end
    endtask

    initial begin : monitor
        logic [1:0] exp_rdy;
        forever begin
            @(posedge CLK);
            model_step();
            #2;
            if (armed) begin
                exp_rdy = (!RST && m_phase == 0 && req_valid != 2'b00)
                        ? (win_of(req_valid, m_ptr) ? 2'b10 : 2'b01) : 2'b00;
                chk("m_req_ready", req_ready, exp_rdy);
                chk("m_busy", busy, m_phase != 0);
                chk("m_grant_id", grant_id, m_gid);
                chk("m_rsp_valid", rsp_valid, (m_phase == 2) ? (m_gid ? 2'b10 : 2'b01) : 2'b00);
                if (m_phase == 2) begin
                    chk("m_rsp_Y", rsp_Y, m_res[W-1:0]);
                    chk("m_rsp_Cout", rsp_Cout, m_res[W]);
                end
                chk("m_alu_A", alu_A, m_a);
                chk("m_alu_B", alu_B, m_b);
                chk("m_alu_opcode", alu_opcode, m_op);
                chk("m_alu_Cin", alu_Cin, m_cin);
            end
        end
    end

    task automatic set_req(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] op, input logic cin);
        req_A[n*W +: W]      = a;
        req_B[n*W +: W]      = b;
        req_opcode[n*4 +: 4] = op;
        req_Cin[n]           = cin;
        req_valid[n]         = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 40) begin @(negedge CLK); k++; end
        chk(name, busy, 1'b0);
    endtask

    task automatic wait_rsp(input string name);
        int k;
        k = 0;
        while (rsp_valid == 2'b00 && k < 40) begin @(negedge CLK); k++; end
        chk(name, rsp_valid != 2'b00, 1'b1);
    endtask

    // Single-op pattern for a LAT=1 operation: accept, two edges, one-cycle handshake.
    task automatic single_op(input string name, input int n, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [3:0] op, input logic cin,
                             input logic [W-1:0] ey, input logic ec);
        set_req(n, a, b, op, cin);
        #1 chk({name, "_ready"}, req_ready, n ? 2'b10 : 2'b01);
        @(negedge CLK);
        req_valid = 2'b00;
        chk({name, "_aluA"}, alu_A, a);
        chk({name, "_aluB"}, alu_B, b);
        chk({name, "_aluop"}, alu_opcode, op);
        chk({name, "_busy"}, busy, 1'b1);
        @(negedge CLK);
        chk({name, "_early"}, rsp_valid, 2'b00);
        @(negedge CLK);
        chk({name, "_valid"}, rsp_valid, n ? 2'b10 : 2'b01);
        chk({name, "_Y"}, rsp_Y, ey);
        chk({name, "_Cout"}, rsp_Cout, ec);
        @(negedge CLK);
        chk({name, "_idle"}, busy, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic gseq[4];
        int   got, k;
        req_valid = 2'b00; req_A = '0; req_B = '0; req_opcode = '0; req_Cin = 2'b00;
        rsp_ready = 2'b11;
        z_req_valid = 2'b00; z_req_A = '0; z_req_B = '0; z_req_opcode = '0; z_req_Cin = 2'b00;
        z_rsp_ready = 2'b11;
        RST = 1'b1;

        // Reset state, and requests held during reset are not acknowledged.
        @(negedge CLK);
        req_valid = 2'b11;
        @(negedge CLK);
        #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_Y", rsp_Y, 16'h0000);
        chk("rst_alu_A", alu_A, 16'h0000);
        chk("rst_grant_id", grant_id, 1'b0);
        req_valid = 2'b00;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        single_op("t033", 0, 16'h0001, 16'h0002, 4'h0, 1'b1, 16'h0004, 1'b0);
        single_op("t034", 1, 16'hFFFF, 16'h0001, 4'h0, 1'b0, 16'h0000, 1'b1);
        single_op("tops", 0, 16'hF0F0, 16'h0FF0, 4'hA, 1'b0, 16'hFF00, 1'b0);

        // Both requesters held high straight out of reset.
        RST = 1'b1;
        set_req(0, 16'h0010, 16'h0020, 4'h0, 1'b0);
        set_req(1, 16'h0100, 16'h0200, 4'h0, 1'b1);
        @(negedge CLK);
        RST = 1'b0;
        got = 0; k = 0;
        while (got < 4 && k < 100) begin
            #1;
            chk("t035_not_both", req_ready == 2'b11, 1'b0);
            if (req_ready != 2'b00) begin gseq[got] = req_ready[1]; got++; end
            @(negedge CLK);
            k++;
        end
        req_valid = 2'b00;
        chk("t035_count", got, 4);
        for (int i = 0; i < 4; i++) chk("t035_grant", (i < got) ? gseq[i] : 1'bx, i % 2);
        wait_idle("t035_idle");

        // Owner withholds rsp_ready; requester 0 waits and owner-0 ready is ignored.
        rsp_ready = 2'b01;
        @(negedge CLK);
        set_req(1, 16'h1234, 16'h1111, 4'h0, 1'b1);
        @(negedge CLK);
        req_valid = 2'b00;
        wait_rsp("t036_rsp");
        req_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t036_valid", rsp_valid, 2'b10);
            chk("t036_Y", rsp_Y, 16'h2346);
            chk("t036_ready", req_ready, 2'b00);
            chk("t036_busy", busy, 1'b1);
            @(negedge CLK);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge CLK);
        chk("t036_idle", busy, 1'b0);
        chk("t036_cleared", rsp_valid, 2'b00);

        // Reset pulse while executing: operation vanishes, pointer back to 0.
        set_req(0, 16'h0005, 16'h0006, 4'h0, 1'b0);
        @(negedge CLK);
        req_valid = 2'b00;
        chk("t037_exec", busy, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t037_busy", busy, 1'b0);
            chk("t037_rsp", rsp_valid, 2'b00);
            @(negedge CLK);
        end
        set_req(0, 16'h0007, 16'h0008, 4'h0, 1'b1);
        set_req(1, 16'h0009, 16'h000A, 4'h0, 1'b0);
        #1 chk("t037_grant0", req_ready, 2'b01);
        @(negedge CLK);
        req_valid = 2'b00;
        wait_rsp("t037_rsp_wait");
        chk("t037_valid", rsp_valid, 2'b01);
        chk("t037_Y", rsp_Y, 16'h0010);
        wait_idle("t037_idle");

        // Zero-latency instance with a combinational ALU.
        z_req_A[15:0] = 16'h1234; z_req_B[15:0] = 16'h0F0F; z_req_opcode[3:0] = 4'h0;
        z_req_Cin[0] = 1'b1; z_req_valid = 2'b01;
        #1 chk("t038_ready", z_req_ready, 2'b01);
        @(negedge CLK);
        z_req_valid = 2'b00;
        chk("t038_early", z_rsp_valid, 2'b00);
        @(negedge CLK);
        chk("t038_valid", z_rsp_valid, 2'b01);
        chk("t038_Y", z_rsp_Y, 16'h2144);
        chk("t038_Cout", z_rsp_Cout, 1'b0);
        @(negedge CLK);
        z_req_A[31:16] = 16'h8000; z_req_B[31:16] = 16'h8000; z_req_opcode[7:4] = 4'h0;
        z_req_Cin[1] = 1'b1; z_req_valid = 2'b10;
        #1 chk("t038b_ready", z_req_ready, 2'b10);
        @(negedge CLK);
        z_req_valid = 2'b00;
        @(negedge CLK);
        chk("t038b_valid", z_rsp_valid, 2'b10);
        chk("t038b_Y", z_rsp_Y, 16'h0001);
        chk("t038b_Cout", z_rsp_Cout, 1'b1);
        @(negedge CLK);
        chk("t038b_idle", z_busy, 1'b0);

        repeat (2) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
